writeback_unit: RTL
===================

Name: writeback_unit

Overview:
Parametrised writeback stage for the pipelined accumulator CPU. It generalises the single-AC writeback into a NUM_REGS x DATA_W register file, with register 0 as the architectural accumulator. It selects between the ALU result and memory load data, stalls on late memory data using a valid/ready handshake, and supports a sticky halt. It also provides bypassed read ports to decode and a retired-instruction counter.

Parameters:
DATA_W, 16, register and datapath width in bits
NUM_REGS, 4, number of architectural registers; reg 0 is AC; must be ≥ 2
REG_AW, $clog2(NUM_REGS), destination/read address width (derived, not overridden)
RET_W, 16, retired-instruction counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
halt_program  in  1  level halt request; stop accepting instructions
in_valid  in  1  instruction from memory stage is valid
in_ready  out  1  stage can accept an instruction this cycle
in_we  in  1  instruction writes a register
in_dest  in  REG_AW  destination register index
in_sel_mem  in  1  1 = write mem_data, 0 = write alu_result
alu_result  in  DATA_W  ALU result for the accepted instruction
mem_valid  in  1  mem_data valid this cycle
mem_data  in  DATA_W  memory load data
rd_addr_a  in  REG_AW  decode read port A address
rd_data_a  out  DATA_W  read port A data, with bypass
rd_addr_b  in  REG_AW  decode read port B address
rd_data_b  out  DATA_W  read port B data, with bypass
ac  out  DATA_W  register 0 contents
halted  out  1  stage is in HALTED
retired  out  RET_W  saturating count of completed instructions

Behaviour:
- Reset (rst low, async): all registers 0, ac=0, retired=0, state RUN, hold registers cleared, halt_pending=0, halted=0.
- States:
  - RUN: in_ready = !halt_program.
  - WAIT_MEM: in_ready=0.
  - HALTED: in_ready=0, halted=1.
- Accept condition: in_valid && in_ready.
- RUN, accept, and (in_sel_mem==0 or mem_valid==1):
  - Commit at this clock edge; 1-cycle latency.
  - Data written is alu_result or mem_data.
- RUN, accept, in_sel_mem==1, mem_valid==0:
  - Latch in_we/in_dest into hold registers; next state WAIT_MEM.
- WAIT_MEM, mem_valid==1:
  - Commit mem_data to the held dest (if held we).
  - Next state HALTED if halt_pending, else RUN.
- WAIT_MEM, mem_valid==0: stay; no commit.
- Halt request in RUN:
  - halt_program high → next state HALTED.
  - A simultaneous in_valid is not accepted (halt wins).
- Halt request in WAIT_MEM:
  - halt_program high sets halt_pending; the outstanding load completes first.
- HALTED is sticky until reset; halt_program deassertion has no effect.
- Commit rules:
  - Write occurs only if we==1 and dest < NUM_REGS; out-of-range dest is dropped silently.
  - retired increments by 1 on every commit (including we=0 and dropped dest).
  - retired saturates at 2^RET_W−1.
- mem_valid outside WAIT_MEM and outside an accepting mem instruction is ignored.
- Read ports are combinational. If a commit writes addr X this cycle, a read of X returns the committing data (write-through bypass); otherwise it returns the stored value. Out-of-range read address returns 0.
- ac always equals stored reg 0, not bypassed.
- At most one commit per cycle.

Decomposition:
- Package wb_pkg holds:
  - state enum {RUN, WAIT_MEM, HALTED}
  - the AC_IDX=0 constant
  - the sel encoding constants SEL_ALU=0, SEL_MEM=1
- One sub-module, wb_regfile: NUM_REGS x DATA_W storage, one write port, two bypassed read ports, async active-low clear.
- FSM, hold registers and counter live in writeback_unit.

Test Plan:
1. ALU write to AC:
   - Stimulus: after reset, in_valid=1, we=1, dest=0, sel=0, alu_result=16'h1234 for one cycle.
   - Required: next cycle ac=16'h1234, retired=1; rd_data_a (addr 0) shows 16'h1234 in the commit cycle via bypass.
2. Late load:
   - Stimulus: accept we=1, dest=2, sel=1 with mem_valid=0; then mem_valid low 3 cycles; then mem_data=16'hBEEF, mem_valid=1.
   - Required: in_ready=0 for 4 cycles; reg2=16'hBEEF after the valid edge; retired=1; back in RUN.
3. Halt collision:
   - Stimulus: halt_program=1 same cycle as in_valid with alu_result=16'h0055.
   - Required: in_ready=0, no write, retired unchanged; halted=1 next cycle; halted stays 1 after halt_program drops.
4. Halt during WAIT_MEM:
   - Stimulus: pending load to dest 1; pulse halt_program; then mem_valid with 16'h00AA.
   - Required: reg1=16'h00AA, retired increments, then halted=1.
5. Boundaries:
   - Stimulus: with RET_W=4, retire 20 we=0 instructions; also send write to dest ≥ NUM_REGS (NUM_REGS=3).
   - Required: retired=4'hF and holds; registers unchanged.
6. Reset mid-operation:
   - Stimulus: assert rst low asynchronously while in WAIT_MEM with nonzero regs.
   - Required: immediately ac=0, all reads 0, retired=0, halted=0; after release in_ready=1, and a stale mem_valid causes no write.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
package wb_pkg;

    // Writeback FSM states
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_MEM = 2'd1,
        HALTED   = 2'd2
    } wb_state_e;

    // Architectural accumulator lives in register 0
    localparam int AC_IDX = 0;

    // Write-data source select encoding
    localparam logic SEL_ALU = 1'b0;
    localparam logic SEL_MEM = 1'b1;

endpackage

// File: rtl/wb_regfile.sv
// NUM_REGS x DATA_W register file: one write port, two write-through read
// ports, accumulator tap, asynchronous active-low clear.
module wb_regfile
    import wb_pkg::*;
#(
    parameter int  DATA_W   = 16,
    parameter int  NUM_REGS = 4,
    localparam int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [REG_AW-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [REG_AW-1:0] rd_addr_a_i,
    output logic [DATA_W-1:0] rd_data_a_o,
    input  logic [REG_AW-1:0] rd_addr_b_i,
    output logic [DATA_W-1:0] rd_data_b_o,
    output logic [DATA_W-1:0] ac_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // Storage: address decode by loop so out-of-range writes match nothing
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                if (we_i && wr_addr_i == REG_AW'(i)) regs_q[i] <= wr_data_i;
        end
    end

    // Read port A: bypass a same-cycle write, out-of-range reads return 0
    always_comb begin
        rd_data_a_o = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (rd_addr_a_i == REG_AW'(i))
                rd_data_a_o = (we_i && wr_addr_i == rd_addr_a_i) ? wr_data_i : regs_q[i];
    end

    // Read port B: same behaviour as port A
    always_comb begin
        rd_data_b_o = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (rd_addr_b_i == REG_AW'(i))
                rd_data_b_o = (we_i && wr_addr_i == rd_addr_b_i) ? wr_data_i : regs_q[i];
    end

    // Accumulator reflects stored state only, never the bypass
    assign ac_o = regs_q[AC_IDX];

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: selects ALU or load data, stalls for late loads,
// sticky halt, retired-instruction counter, bypassed register file.
module writeback_unit
    import wb_pkg::*;
#(
    parameter int  DATA_W   = 16,
    parameter int  NUM_REGS = 4,
    parameter int  RET_W    = 16,
    localparam int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt_program,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_we,
    input  logic [REG_AW-1:0] in_dest,
    input  logic              in_sel_mem,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [REG_AW-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] ac,
    output logic              halted,
    output logic [RET_W-1:0]  retired
);

    wb_state_e         state_q;
    logic              hold_we_q;
    logic [REG_AW-1:0] hold_dest_q;
    logic              halt_pending_q;
    logic              halted_q;
    logic [RET_W-1:0]  retired_q, retired_d;

    logic              accept;
    logic              commit;
    logic              commit_we;
    logic [REG_AW-1:0] commit_dest;
    logic [DATA_W-1:0] commit_data;

    function automatic logic [RET_W-1:0] sat_inc(input logic [RET_W-1:0] v);
        return (v == {RET_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Halt request wins over a same-cycle instruction
    assign in_ready = (state_q == RUN) && !halt_program;
    assign accept   = in_valid && in_ready;

    // Commit select: immediate commit in RUN, or load completion in WAIT_MEM
    always_comb begin
        commit      = 1'b0;
        commit_we   = 1'b0;
        commit_dest = in_dest;
        commit_data = alu_result;
        case (state_q)
            RUN: begin
                if (accept && (in_sel_mem == SEL_ALU || mem_valid)) begin
                    commit      = 1'b1;
                    commit_we   = in_we;
                    commit_dest = in_dest;
                    commit_data = (in_sel_mem == SEL_MEM) ? mem_data : alu_result;
                end
            end
            WAIT_MEM: begin
                if (mem_valid) begin
                    commit      = 1'b1;
                    commit_we   = hold_we_q;
                    commit_dest = hold_dest_q;
                    commit_data = mem_data;
                end
            end
            default: ;
        endcase
    end

    // Control FSM with hold registers and registered halted flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= RUN;
            hold_we_q      <= 1'b0;
            hold_dest_q    <= '0;
            halt_pending_q <= 1'b0;
            halted_q       <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (halt_program) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end else if (accept && in_sel_mem == SEL_MEM && !mem_valid) begin
                        state_q     <= WAIT_MEM;
                        hold_we_q   <= in_we;
                        hold_dest_q <= in_dest;
                    end
                end
                WAIT_MEM: begin
                    if (mem_valid) begin
                        halt_pending_q <= 1'b0;
                        if (halt_pending_q || halt_program) begin
                            state_q  <= HALTED;
                            halted_q <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end else if (halt_program) begin
                        halt_pending_q <= 1'b1;
                    end
                end
                HALTED:  halted_q <= 1'b1;
                default: state_q  <= RUN;
            endcase
        end
    end

    // Retired counter next state: saturating increment per commit
    always_comb begin
        retired_d = retired_q;
        if (commit) retired_d = sat_inc(retired_q);
    end

    // Retired counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) retired_q <= '0;
        else      retired_q <= retired_d;
    end

    assign halted  = halted_q;
    assign retired = retired_q;

    wb_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk         (clk),
        .rst         (rst),
        .we_i        (commit && commit_we),
        .wr_addr_i   (commit_dest),
        .wr_data_i   (commit_data),
        .rd_addr_a_i (rd_addr_a),
        .rd_data_a_o (rd_data_a),
        .rd_addr_b_i (rd_addr_b),
        .rd_data_b_o (rd_data_b),
        .ac_o        (ac)
    );

endmodule
